// File: rtl/rng_share_if.sv
// Handshake bundle between the neuron-core noise ports and the shared RNG arbiter.
// The master side issues requests and seeds; the slave side returns granted bytes.
interface rng_share_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic               seed_load;
  logic [31:0]        seed_value;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               rand_valid;
  logic [7:0]         rand_data;
  logic [ID_W-1:0]    rand_id;
  logic               ready;

  modport master (
    output seed_load, seed_value, req,
    input  grant, rand_valid, rand_data, rand_id, ready
  );

  modport slave (
    input  seed_load, seed_value, req,
    output grant, rand_valid, rand_data, rand_id, ready
  );
endinterface

// File: rtl/rng_share_arbiter.sv
// 32-bit xorshift (13/17/5) noise source shared round-robin among NUM_REQ requesters;
// each grant advances the generator one step and hands out one byte.
//   state    | meaning
//   S_WARMUP | discarding cnt generator steps after reset/reseed, no grants
//   S_RUN    | one step and one byte per grant, generator idle without requests
module rng_share_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [31:0] SEED    = 32'd2463534242,
  parameter int          WARMUP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rng_share_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {S_WARMUP, S_RUN} fsm_t;

  fsm_t               r_fsm,   w_fsm_nxt;
  logic [31:0]        r_state, w_state_nxt;
  logic [7:0]         r_cnt,   w_cnt_nxt;
  logic [ID_W-1:0]    r_ptr,   w_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_valid, w_valid_nxt;
  logic [7:0]         r_data,  w_data_nxt;
  logic [ID_W-1:0]    r_id,    w_id_nxt;

  logic [31:0]        w_step;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_ptr_after;
  logic               w_any;

  function automatic logic [31:0] xs_step(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign w_step = xs_step(r_state);
  assign w_any  = |bus.req;

  // First set request bit at or after the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    logic found;
    found    = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx[ID_W-1:0]]) begin
        found    = 1'b1;
        w_winner = idx[ID_W-1:0];
      end
    end
  end

  assign w_ptr_after = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = '0;
    w_valid_nxt = 1'b0;
    w_id_nxt    = '0;
    w_data_nxt  = r_data;

    // Reseed overrides any pending grant; the pointer is deliberately kept.
    if (bus.seed_load) begin
      w_state_nxt = (bus.seed_value == 32'd0) ? SEED : bus.seed_value;
      w_cnt_nxt   = 8'(WARMUP);
      w_fsm_nxt   = S_WARMUP;
    end else begin
      case (r_fsm)
        S_WARMUP: begin
          if (r_cnt != 8'd0) begin
            w_state_nxt = w_step;
            w_cnt_nxt   = r_cnt - 8'd1;
          end else begin
            w_fsm_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (w_any) begin
            w_state_nxt           = w_step;
            w_grant_nxt[w_winner] = 1'b1;
            w_valid_nxt           = 1'b1;
            w_id_nxt              = w_winner;
            w_data_nxt            = w_step[7:0];
            w_ptr_nxt             = w_ptr_after;
          end
        end
        default: w_fsm_nxt = S_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_WARMUP;
      r_state <= SEED;
      r_cnt   <= 8'(WARMUP);
      r_ptr   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_data  <= 8'd0;
      r_id    <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.rand_valid = r_valid;
  assign bus.rand_data  = r_data;
  assign bus.rand_id    = r_id;
  assign bus.ready      = (r_fsm == S_RUN);
endmodule

// File: tb/tb_rng_share_arbiter.sv
// Bench for rng_share_arbiter: two instances (WARMUP=0 and WARMUP=8) share stimulus;
// a behavioural model pushes expected outputs per cycle, popped after the edge.
module tb_rng_share_arbiter;
  localparam int          NR   = 4;
  localparam logic [31:0] SEED = 32'd2463534242;

  typedef struct packed {
    logic          valid;
    logic [NR-1:0] grant;
    logic [1:0]    id;
    logic [7:0]    data;
    logic          ready;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r_load = 1'b0;
  logic [31:0]   r_val = 32'd0;
  logic [NR-1:0] r_req = '0;

  always #5 clk = ~clk;

  rng_share_if #(.NUM_REQ(NR)) if0 ();
  rng_share_if #(.NUM_REQ(NR)) if8 ();

  assign if0.seed_load  = r_load;
  assign if0.seed_value = r_val;
  assign if0.req        = r_req;
  assign if8.seed_load  = r_load;
  assign if8.seed_value = r_val;
  assign if8.req        = r_req;

  rng_share_arbiter #(.NUM_REQ(NR), .SEED(SEED), .WARMUP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rng_share_arbiter #(.NUM_REQ(NR), .SEED(SEED), .WARMUP(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave));

  int n_tests = 0;
  int n_fail  = 0;

  obs_t sb[$];
  obs_t obs[2];
  obs_t e;

  logic [31:0] m_state[2];
  int          m_cnt[2];
  bit          m_run[2];
  int          m_ptr[2];
  logic [7:0]  m_data[2];
  int          m_warm[2] = '{0, 8};

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] a, b;
    a = s ^ {s[18:0], 13'b0};
    b = a ^ {17'b0, a[31:17]};
    return b ^ {b[26:0], 5'b0};
  endfunction

  function void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = SEED;
      m_cnt[d]   = m_warm[d];
      m_run[d]   = 1'b0;
      m_ptr[d]   = 0;
      m_data[d]  = 8'd0;
    end
  endfunction

  function obs_t model_edge(input int d, input logic [NR-1:0] req,
                            input logic load, input logic [31:0] val);
    obs_t o;
    int   w;
    o = '0;
    if (load) begin
      m_state[d] = (val == 0) ? SEED : val;
      m_cnt[d]   = m_warm[d];
      m_run[d]   = 1'b0;
    end else if (!m_run[d]) begin
      if (m_cnt[d] > 0) begin
        m_state[d] = xs(m_state[d]);
        m_cnt[d]   = m_cnt[d] - 1;
      end else begin
        m_run[d] = 1'b1;
      end
    end else if (req != 0) begin
      w = -1;
      for (int i = 0; i < NR; i++)
        if (w < 0 && req[(m_ptr[d] + i) % NR]) w = (m_ptr[d] + i) % NR;
      m_state[d] = xs(m_state[d]);
      m_data[d]  = m_state[d][7:0];
      o.valid    = 1'b1;
      o.grant    = NR'(1) << w;
      o.id       = 2'(w);
      m_ptr[d]   = (w + 1) % NR;
    end
    o.data  = m_data[d];
    o.ready = m_run[d];
    return o;
  endfunction

  task automatic drive(input logic [NR-1:0] req, input logic load = 1'b0,
                       input logic [31:0] val = 32'd0);
    r_req  = req;
    r_load = load;
    r_val  = val;
    for (int d = 0; d < 2; d++) sb.push_back(model_edge(d, req, load, val));
    @(posedge clk);
    #1;
    r_load = 1'b0;
    obs[0] = {if0.rand_valid, if0.grant, if0.rand_id, if0.rand_data, if0.ready};
    obs[1] = {if8.rand_valid, if8.grant, if8.rand_id, if8.rand_data, if8.ready};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    r_req  = '0;
    r_load = 1'b0;
    r_val  = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    obs[0] = {if0.rand_valid, if0.grant, if0.rand_id, if0.rand_data, if0.ready};
    obs[1] = {if8.rand_valid, if8.grant, if8.rand_id, if8.rand_data, if8.ready};
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs[d] !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got %h want 0", d, obs[d]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive((c == 1) ? 4'b0001 : 4'b0000);
      for (int d = 0; d < 2; d++) begin
        e = sb.pop_front();
        n_tests++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL reset_seq c%0d dut%0d got %h want %h", c, d, obs[d], e);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (obs[0].valid !== 1'b1 || obs[0].grant !== 4'b0001 ||
            obs[0].id !== 2'd0 || obs[0].data !== 8'h63) begin
          n_fail++;
          $display("FAIL first_byte got v%b g%b id%0d d%h want v1 g0001 id0 d63",
                   obs[0].valid, obs[0].grant, obs[0].id, obs[0].data);
        end
      end
      if (c == 2) begin
        n_tests++;
        if (obs[0].valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_valid got %b want 0", obs[0].valid);
        end
      end
    end
  endtask

  task automatic test_warmup();
    int first;
    first = -1;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      drive(4'b0001);
      for (int d = 0; d < 2; d++) begin
        e = sb.pop_front();
        n_tests++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL warmup c%0d dut%0d got %h want %h", c, d, obs[d], e);
        end
      end
      if (first < 0 && obs[1].valid === 1'b1) first = c;
    end
    n_tests++;
    if (first != 9) begin
      n_fail++;
      $display("FAIL warmup_len got %0d want 9", first);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    drive(4'b0000);
    void'(sb.pop_front());
    void'(sb.pop_front());
    for (int k = 0; k < 14; k++) begin
      drive((k < 8) ? 4'b1111 : 4'b1010);
      for (int d = 0; d < 2; d++) begin
        e = sb.pop_front();
        n_tests++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL rr k%0d dut%0d got %h want %h", k, d, obs[d], e);
        end
      end
      n_tests++;
      if (obs[0].id !== ((k < 8) ? 2'(k % 4) : ((k % 2 == 0) ? 2'd1 : 2'd3)) ||
          !$onehot(obs[0].grant)) begin
        n_fail++;
        $display("FAIL rr_id k%0d got id%0d g%b", k, obs[0].id, obs[0].grant);
      end
    end
  endtask

  task automatic test_reseed_zero();
    for (int k = 0; k < 6; k++) begin
      drive(4'b1111, (k == 2), 32'd0);
      for (int d = 0; d < 2; d++) begin
        e = sb.pop_front();
        n_tests++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL reseed0 k%0d dut%0d got %h want %h", k, d, obs[d], e);
        end
      end
      if (k == 2) begin
        n_tests++;
        if (obs[0].valid !== 1'b0 || obs[0].grant !== 4'b0000) begin
          n_fail++;
          $display("FAIL reseed_nogrant got v%b g%b want v0 g0000", obs[0].valid, obs[0].grant);
        end
      end
      if (k == 4) begin
        n_tests++;
        if (obs[0].data !== 8'h63 || obs[0].id !== 2'd2) begin
          n_fail++;
          $display("FAIL reseed0_first got d%h id%0d want d63 id2", obs[0].data, obs[0].id);
        end
      end
    end
  endtask

  task automatic test_seed_one();
    for (int k = 0; k < 4; k++) begin
      drive((k >= 2) ? 4'b0001 : 4'b0000, (k == 0), 32'd1);
      for (int d = 0; d < 2; d++) begin
        e = sb.pop_front();
        n_tests++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL seed1 k%0d dut%0d got %h want %h", k, d, obs[d], e);
        end
      end
      if (k == 2) begin
        n_tests++;
        if (obs[0].valid !== 1'b1 || obs[0].data !== 8'h21) begin
          n_fail++;
          $display("FAIL seed1_byte got v%b d%h want v1 d21", obs[0].valid, obs[0].data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? 4'b0000 : 4'b1111);
      for (int d = 0; d < 2; d++) void'(sb.pop_front());
    end
    rst_n = 1'b0;
    model_reset();
    for (int h = 0; h < 2; h++) begin
      #1;
      obs[0] = {if0.rand_valid, if0.grant, if0.rand_id, if0.rand_data, if0.ready};
      obs[1] = {if8.rand_valid, if8.grant, if8.rand_id, if8.rand_data, if8.ready};
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs[d] !== obs_t'(0)) begin
          n_fail++;
          $display("FAIL mid_reset h%0d dut%0d got %h want 0", h, d, obs[d]);
        end
      end
      if (h == 0) @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive((k == 0) ? 4'b0000 : 4'b1111);
      for (int d = 0; d < 2; d++) begin
        e = sb.pop_front();
        n_tests++;
        if (obs[d] !== e) begin
          n_fail++;
          $display("FAIL post_reset k%0d dut%0d got %h want %h", k, d, obs[d], e);
        end
      end
      if (k == 1) begin
        n_tests++;
        if (obs[0].data !== 8'h63 || obs[0].id !== 2'd0) begin
          n_fail++;
          $display("FAIL post_reset_first got d%h id%0d want d63 id0", obs[0].data, obs[0].id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_round_robin();
    test_reseed_zero();
    test_seed_one();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
